// File: rtl/ram_sdp_sync_read.sv
// Simple-dual-port synchronous-read RAM: byte-lane writes, selectable
// read-during-write behaviour, optional output register and a post-reset clear engine.
module ram_sdp_sync_read #(
  parameter int AWIDTH   = 3,
  parameter int DWIDTH   = 32,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0,
  parameter int CLEAR_EN = 1,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [AWIDTH-1:0]      wr_addr,
  input  logic [DWIDTH/8-1:0]    wr_be,
  input  logic [DWIDTH-1:0]      wr_data,
  input  logic                   rd_en,
  input  logic [AWIDTH-1:0]      rd_addr,
  output logic [DWIDTH-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   init_busy
);

  localparam int NBYTES = DWIDTH / 8;
  localparam int DEPTH  = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_e;

  localparam state_e RST_STATE = (CLEAR_EN != 0) ? S_CLEAR : S_IDLE;

  state_e state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              idle;
  logic              wr_acc;
  logic              rd_acc;
  logic              same_addr;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] wr_merge;
  logic [DWIDTH-1:0] rd_word;

  logic              p0_valid_q, p0_valid_d;
  logic [DWIDTH-1:0] p0_data_q, p0_data_d;
  logic              p1_valid_q, p1_valid_d;
  logic [DWIDTH-1:0] p1_data_q, p1_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DWIDTH-1:0] rd_data_q, rd_data_d;
  logic              tail_valid;
  logic [DWIDTH-1:0] tail_data;

  assign idle   = (state_q == S_IDLE);
  assign wr_acc = idle && wr_en;
  assign rd_acc = idle && rd_en;

  // Word as it will look after this edge's write: new lanes, old elsewhere.
  always_comb begin
    wr_merge = mem[wr_addr];
    for (int i = 0; i < NBYTES; i++) begin
      if (wr_be[i]) begin
        wr_merge[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_merge;
    unique case (state_q)
      S_CLEAR: begin
        mem_we    = !reset;
        mem_waddr = cnt_q;
        mem_wdata = INIT_VAL;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        mem_we = wr_en && !reset;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    same_addr = wr_acc && (wr_addr == rd_addr);
    rd_word   = mem[rd_addr];
    if ((RDW_MODE != 0) && same_addr) begin
      rd_word = wr_merge;
    end
  end

  // Data is captured on the accepting edge so old-data mode sees the pre-write word.
  always_comb begin
    p0_valid_d = rd_acc;
    p0_data_d  = rd_acc ? rd_word : p0_data_q;
    p1_valid_d = p0_valid_q;
    p1_data_d  = p0_valid_q ? p0_data_q : p1_data_q;
    tail_valid = (OUT_REG != 0) ? p1_valid_q : p0_valid_q;
    tail_data  = (OUT_REG != 0) ? p1_data_q : p0_data_q;
    rd_valid_d = tail_valid;
    rd_data_d  = tail_valid ? tail_data : rd_data_q;
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      p0_valid_q <= 1'b0;
      p0_data_q  <= '0;
      p1_valid_q <= 1'b0;
      p1_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p0_valid_q <= p0_valid_d;
      p0_data_q  <= p0_data_d;
      p1_valid_q <= p1_valid_d;
      p1_data_q  <= p1_data_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign init_busy = (state_q == S_CLEAR);

endmodule

// File: tb/tb_ram_sdp_sync_read.sv
// Bench for ram_sdp_sync_read: two configurations share stimulus and are
// compared every cycle against an array/queue reference of the RAM behaviour.
module tb_ram_sdp_sync_read;

  localparam int DEPTH = 8;

  logic        clock;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic        init_busy0, init_busy1;

  int n_checks = 0;
  int n_errors = 0;

  ram_sdp_sync_read #(
    .AWIDTH(3), .DWIDTH(32), .OUT_REG(0), .RDW_MODE(0),
    .CLEAR_EN(1), .INIT_VAL(32'h0)
  ) dut0 (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .init_busy(init_busy0)
  );

  ram_sdp_sync_read #(
    .AWIDTH(3), .DWIDTH(32), .OUT_REG(1), .RDW_MODE(1),
    .CLEAR_EN(1), .INIT_VAL(32'h0)
  ) dut1 (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(init_busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last0, last1;
  logic [31:0] old_w, nxt_w;
  int          nclr = 0;
  int          cyc = 0;

  always @(posedge clock) begin
    if (reset) begin
      q0.delete();
      q1.delete();
      nclr  = 0;
      last0 = '0;
      last1 = '0;
    end else begin
      cyc++;
      if (nclr < DEPTH) begin
        ref_mem[nclr] = '0;
        nclr++;
      end else begin
        old_w = ref_mem[rd_addr];
        nxt_w = ref_mem[wr_addr];
        for (int i = 0; i < 4; i++)
          if (wr_be[i]) nxt_w[8*i +: 8] = wr_data[8*i +: 8];
        if (wr_en) ref_mem[wr_addr] = nxt_w;
        if (rd_en) begin
          q0.push_back('{cyc + 1, old_w});
          q1.push_back('{cyc + 2, ref_mem[rd_addr]});
        end
      end
    end
    #1;
    if (reset) begin
      check("rst_busy0", {31'b0, init_busy0}, 32'd1);
      check("rst_busy1", {31'b0, init_busy1}, 32'd1);
      check("rst_rv0", {31'b0, rd_valid0}, 32'd0);
      check("rst_rv1", {31'b0, rd_valid1}, 32'd0);
      check("rst_rd0", rd_data0, 32'd0);
      check("rst_rd1", rd_data1, 32'd0);
    end else begin
      check("busy0", {31'b0, init_busy0}, {31'b0, (nclr < DEPTH)});
      check("busy1", {31'b0, init_busy1}, {31'b0, (nclr < DEPTH)});
      if (q0.size() > 0 && q0[0].due == cyc) begin
        check("rv0", {31'b0, rd_valid0}, 32'd1);
        check("rd0", rd_data0, q0[0].data);
        last0 = q0[0].data;
        void'(q0.pop_front());
      end else begin
        check("rv0_idle", {31'b0, rd_valid0}, 32'd0);
        check("hold0", rd_data0, last0);
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
        check("rv1", {31'b0, rd_valid1}, 32'd1);
        check("rd1", rd_data1, q1[0].data);
        last1 = q1[0].data;
        void'(q1.pop_front());
      end else begin
        check("rv1_idle", {31'b0, rd_valid1}, 32'd0);
        check("hold1", rd_data1, last1);
      end
    end
  end

  task automatic step(input logic we, input logic [2:0] wa,
                      input logic [3:0] be, input logic [31:0] wd,
                      input logic re, input logic [2:0] ra);
    wr_en   = we;
    wr_addr = wa;
    wr_be   = be;
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd0);
  endtask

  task automatic busy_noise();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 3'($urandom_range(7)), 4'hF, $urandom,
           1'b1, 3'($urandom_range(7)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    busy_noise();

    for (int a = 0; a < DEPTH; a++)
      step(1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'(a));
    idle(3);

    step(1'b1, 3'd3, 4'hF, 32'hDEADBEEF, 1'b0, 3'd0);
    step(1'b1, 3'd3, 4'h5, 32'h11223344, 1'b0, 3'd0);
    step(1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd3);
    idle(3);

    step(1'b1, 3'd5, 4'hF, 32'hA5A5A5A5, 1'b1, 3'd5);
    step(1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd5);
    idle(3);

    step(1'b1, 3'd7, 4'hF, 32'hCAFEF00D, 1'b0, 3'd0);
    step(1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd7);
    idle(3);

    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(4);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    busy_noise();
    step(1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd7);
    idle(3);

    step(1'b1, 3'd2, 4'hF, 32'h12345678, 1'b0, 3'd0);
    step(1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd2);
    wr_en = 1'b0;
    rd_en = 1'b1;
    rd_addr = 3'd2;
    @(posedge clock);
    @(negedge clock);
    rd_en = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_rv0", {31'b0, rd_valid0}, 32'd0);
    check("rst_mid_rv1", {31'b0, rd_valid1}, 32'd0);
    check("rst_mid_rd0", rd_data0, 32'd0);
    check("rst_mid_rd1", rd_data1, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle(DEPTH + 4);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(99) < 45), 3'($urandom_range(7)),
           4'($urandom_range(15)), $urandom,
           ($urandom_range(99) < 60), 3'($urandom_range(7)));
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
